// File: rtl/lii_out_packer.sv
// Packs kernel output words into multi-lane LII beats, one word per lane.
// A frame boundary always closes the current beat, zero-padding the unused upper lanes.
module lii_out_packer #(
   parameter int         PW          = 128,
   parameter int         DW          = 24,
   parameter int         LW          = 32,
   parameter int         FRAME_WORDS = 10,
   parameter logic [7:0] SRC_ID      = 8'h00,
   parameter logic [7:0] DST_ID      = 8'h01
) (
   input  logic          aclk,
   input  logic          arst,
   input  logic [DW-1:0] out_stream_tdata,
   input  logic          out_stream_tvalid,
   output logic          out_stream_tready,
   output logic [PW-1:0] lii_out_p0_tdata,
   output logic          lii_out_p0_tvalid,
   input  logic          lii_out_p0_tready,
   output logic [7:0]    lii_out_p0_src,
   output logic [7:0]    lii_out_p0_dst,
   output logic          ce,
   output logic [31:0]   beats_sent
);

   localparam int LANES = PW / LW;
   localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int FCW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [LCW-1:0] LANE_LAST  = LCW'(LANES - 1);
   localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_WORDS - 1);

   logic [PW-1:0]  acc_reg;
   logic [PW-1:0]  out_data_reg;
   logic           out_valid_reg;
   logic [LCW-1:0] lane_cnt_reg;
   logic [FCW-1:0] frame_cnt_reg;
   logic [31:0]    beats_reg;
   logic           run_reg;

   logic [LW-1:0]  word_ext;
   logic [PW-1:0]  merged;
   logic           beat_done;
   logic           ready;
   logic           accept;
   logic           transfer;

   assign word_ext  = LW'(out_stream_tdata);
   assign beat_done = (lane_cnt_reg == LANE_LAST) || (frame_cnt_reg == FRAME_LAST);

   // Stall only when this word would close a beat and the previous beat cannot leave.
   assign ready    = run_reg & ~(beat_done & out_valid_reg & ~lii_out_p0_tready);
   assign accept   = out_stream_tvalid & ready;
   assign transfer = out_valid_reg & lii_out_p0_tready;

   // Lanes below the write pointer keep their data; lanes above it are forced to zero.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign merged[gi*LW +: LW] = (lane_cnt_reg == LCW'(gi)) ? word_ext :
                                      (lane_cnt_reg >  LCW'(gi)) ? acc_reg[gi*LW +: LW] :
                                                                   '0;
      end
   endgenerate

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         acc_reg       <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         lane_cnt_reg  <= '0;
         frame_cnt_reg <= '0;
         beats_reg     <= '0;
         run_reg       <= 1'b0;
      end else begin
         run_reg <= 1'b1;
         if (transfer) begin
            beats_reg <= beats_reg + 32'd1;
         end
         if (transfer && !(accept && beat_done)) begin
            out_valid_reg <= 1'b0;
         end
         if (accept) begin
            frame_cnt_reg <= (frame_cnt_reg == FRAME_LAST) ? '0 : frame_cnt_reg + FCW'(1);
            if (beat_done) begin
               out_data_reg  <= merged;
               out_valid_reg <= 1'b1;
               acc_reg       <= '0;
               lane_cnt_reg  <= '0;
            end else begin
               acc_reg      <= merged;
               lane_cnt_reg <= lane_cnt_reg + LCW'(1);
            end
         end
      end
   end

   assign out_stream_tready = ready;
   assign ce                = ready;
   assign lii_out_p0_tdata  = out_data_reg;
   assign lii_out_p0_tvalid = out_valid_reg;
   assign lii_out_p0_src    = SRC_ID;
   assign lii_out_p0_dst    = DST_ID;
   assign beats_sent        = beats_reg;

endmodule

// File: doc/lii_out_packer.md
LII_OUT_PACKER -- requirements
Module: lii_out_packer

Interface
REQ-001 Parameter PW, default 128, LII phy data width in bits.
REQ-002 Parameter DW, default 24, kernel output word width; DW <= LW.
REQ-003 Parameter LW, default 32, lane width; LANES = PW/LW (default 4); PW is a multiple of LW.
REQ-004 Parameter FRAME_WORDS, default 10, kernel words per frame; must be >= 1.
REQ-005 Parameter SRC_ID, default 8'h00, source tag driven on every beat.
REQ-006 Parameter DST_ID, default 8'h01, destination tag driven on every beat.
REQ-007 Ports are one clock and one asynchronous, active-high reset: aclk in 1, clock, all logic on rising edge; arst in 1, asynchronous active-high reset.
REQ-008 out_stream_tdata in DW, kernel output word.
REQ-009 out_stream_tvalid in 1, kernel word valid.
REQ-010 out_stream_tready out 1, packer accepts word.
REQ-011 lii_out_p0_tdata out PW, packed beat.
REQ-012 lii_out_p0_tvalid out 1, beat valid.
REQ-013 lii_out_p0_tready in 1, downstream accepts beat.
REQ-014 lii_out_p0_src out 8, constant SRC_ID.
REQ-015 lii_out_p0_dst out 8, constant DST_ID.
REQ-016 ce out 1, kernel clock enable.
REQ-017 beats_sent out 32, count of LII beats transferred.

Function
REQ-018 Datapath: lane accumulator (PW bits), lane counter (0..LANES-1), frame word counter (0..FRAME_WORDS-1), one-entry output register with valid flag.
REQ-019 Word accept = out_stream_tvalid & out_stream_tready; accepted word zero-extended DW->LW and written to lane[lane_cnt], lane 0 at bits [LW-1:0].
REQ-020 An accept completes a beat when lane_cnt == LANES-1 or frame_cnt == FRAME_WORDS-1.
REQ-021 On completing accept, {accumulator with new lane, all higher lanes forced to 0} is loaded into the output register, lii_out_p0_tvalid = 1 next cycle, accumulator cleared, lane_cnt -> 0.
REQ-022 frame_cnt increments on every accept and wraps to 0 after FRAME_WORDS-1; a frame boundary always forces a partial beat, never merges words of two frames.
REQ-023 out_stream_tready = 0 only when the next accept would complete a beat AND lii_out_p0_tvalid = 1 AND lii_out_p0_tready = 0; otherwise 1 (combinational from lii_out_p0_tready permitted).
REQ-024 Beat transfer = lii_out_p0_tvalid & lii_out_p0_tready; on transfer with no simultaneous completing accept, tvalid -> 0; with simultaneous completing accept, output register reloads and tvalid stays 1 (zero-bubble streaming).
REQ-025 While tvalid = 1 and tready = 0, lii_out_p0_tdata is held stable.
REQ-026 ce = out_stream_tready.
REQ-027 beats_sent increments by 1 per beat transfer, wraps 2^32-1 -> 0.
REQ-028 Latency: completing accept at cycle N -> lii_out_p0_tvalid = 1 at cycle N+1.
REQ-029 Throughput: with tready held 1, one word accepted per cycle, one beat per LANES words.

Reset
REQ-030 arst asserted asynchronously forces: lii_out_p0_tvalid 0, lii_out_p0_tdata 0, accumulator 0, lane_cnt 0, frame_cnt 0, beats_sent 0; src/dst remain constants.
REQ-031 During arst, out_stream_tready and ce are 0; both become 1 the first clock edge after deassertion.
REQ-032 Reset mid-frame discards any partially filled accumulator and pending beat; no beat is emitted for them.

Verification
REQ-033 Defaults, tready = 1, words 1..10 back to back -> beats 0x00000004_00000003_00000002_00000001, 0x00000008_..._00000005, 0x00000000_00000000_0000000A_00000009; beats_sent = 3.
REQ-034 tready = 0 after first beat, feed words 11..14 -> beat 1 held stable, out_stream_tready = 0 and ce = 0 with word 14 on the bus; release tready -> beat transferred, word 14 accepted, next beat emitted next cycle.
REQ-035 Continuous stream of 40 words with tready = 1 -> 12 beats, no idle cycle on out_stream_tready, every 10th word ends a padded beat.
REQ-036 arst pulsed after 2 words of a frame -> no beat emitted; next words 1..4 pack into 0x00000004_00000003_00000002_00000001 as lanes 0-3.
REQ-037 Random tvalid/tready toggling, 1000 words -> scoreboard of unpacked lanes matches input order, held-data check passes, beats_sent equals observed transfers.
